// File: rtl/fetch_queue.sv
// Instruction fetch stage: PC, credit-limited word requests, in-order return queue to decode.
// Optional FETCH_ALIGN_CHECK_EN: flags misaligned redirect targets and halts fetch until an aligned one.
module fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
`ifdef FETCH_ALIGN_CHECK_EN
  output logic        fetch_misaligned,
`endif
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc_plus4
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [31:0]   pc_q, pc_d;
  logic [31:0]   qi_q [DEPTH];
  logic [31:0]   qi_d [DEPTH];
  logic [31:0]   qp_q [DEPTH];
  logic [31:0]   qp_d [DEPTH];
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   pf_q [DEPTH];
  logic [31:0]   pf_d [DEPTH];
  logic [PW-1:0] pfr_q, pfr_d, pfw_q, pfw_d;
  logic [CW-1:0] out_q, out_d;
  logic [CW-1:0] disc_q, disc_d;
  logic          mis;
  logic [31:0]   tgt;
  logic [CW:0]   credit;
  logic          accept, push, pop, drop;

`ifdef FETCH_ALIGN_CHECK_EN
  logic mis_q, mis_d;
  assign mis              = mis_q;
  assign tgt              = redirect_pc;
  assign fetch_misaligned = mis_q;
`else
  assign mis = 1'b0;
  assign tgt = redirect_pc & ~32'h3;
`endif

  // Queue entries plus in-flight words never exceed DEPTH, so a response always has a slot.
  assign credit         = {1'b0, cnt_q} + {1'b0, out_q};
  assign imem_req_valid = reset_n && !redirect_valid && !mis && (credit < (CW+1)'(DEPTH));
  assign imem_req_addr  = pc_q;
  assign accept         = imem_req_valid & imem_req_ready;
  assign drop           = (disc_q != '0);
  assign push           = imem_rsp_valid & !drop & !redirect_valid;
  assign out_valid      = (cnt_q != '0);
  assign pop            = out_valid & out_ready & !redirect_valid;
  assign out_instr      = qi_q[rd_q];
  assign out_pc         = qp_q[rd_q];
  assign out_pc_plus4   = out_pc + 32'd4;

  always_comb begin
    pc_d   = pc_q;
    qi_d   = qi_q;
    qp_d   = qp_q;
    rd_d   = rd_q;
    wr_d   = wr_q;
    cnt_d  = cnt_q;
    pf_d   = pf_q;
    pfr_d  = pfr_q;
    pfw_d  = pfw_q;
    disc_d = disc_q;
`ifdef FETCH_ALIGN_CHECK_EN
    mis_d  = mis_q;
`endif
    // The request PC FIFO tracks every in-flight word, dropped or not.
    if (accept) begin
      pf_d[pfw_q] = pc_q;
      pfw_d       = pfw_q + PW'(1);
      pc_d        = pc_q + 32'd4;
    end
    if (imem_rsp_valid) pfr_d = pfr_q + PW'(1);
    out_d = out_q + CW'(accept) - CW'(imem_rsp_valid);

    if (redirect_valid) begin
      pc_d   = tgt;
      cnt_d  = '0;
      rd_d   = wr_q;
      disc_d = out_q - CW'(imem_rsp_valid);
`ifdef FETCH_ALIGN_CHECK_EN
      mis_d  = (redirect_pc[1:0] != 2'b00);
`endif
    end else begin
      if (imem_rsp_valid && drop) disc_d = disc_q - CW'(1);
      if (push) begin
        qi_d[wr_q] = imem_rsp_data;
        qp_d[wr_q] = pf_q[pfr_q];
        wr_d       = wr_q + PW'(1);
      end
      if (pop) rd_d = rd_q + PW'(1);
      cnt_d = cnt_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q   <= RESET_PC;
      rd_q   <= '0;
      wr_q   <= '0;
      cnt_q  <= '0;
      pfr_q  <= '0;
      pfw_q  <= '0;
      out_q  <= '0;
      disc_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        qi_q[i] <= '0;
        qp_q[i] <= '0;
        pf_q[i] <= '0;
      end
`ifdef FETCH_ALIGN_CHECK_EN
      mis_q  <= 1'b0;
`endif
    end else begin
      pc_q   <= pc_d;
      rd_q   <= rd_d;
      wr_q   <= wr_d;
      cnt_q  <= cnt_d;
      pfr_q  <= pfr_d;
      pfw_q  <= pfw_d;
      out_q  <= out_d;
      disc_q <= disc_d;
      qi_q   <= qi_d;
      qp_q   <= qp_d;
      pf_q   <= pf_d;
`ifdef FETCH_ALIGN_CHECK_EN
      mis_q  <= mis_d;
`endif
    end
  end
endmodule
